// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time,
// and hands fetched instructions to decode over a valid/ready handshake.
module fetch_pc_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] PC_STEP  = 64'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] add_a,
  output logic [63:0] add_b,
  input  logic [63:0] add_out,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state_q;
  logic [63:0] pc_q;
  logic [63:0] pend_q;
  logic [63:0] if_pc_q;
  logic [31:0] if_instr_q;
  logic [31:0] cnt_q;
  logic [63:0] tgt;

  assign tgt = {redirect_pc[63:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pend_q     <= 64'h0;
      if_pc_q    <= 64'h0;
      if_instr_q <= 32'h0;
      cnt_q      <= 32'h0;
    end else begin
      unique case (state_q)
        BOOT: begin
          if (redirect_valid) pc_q <= tgt;
          state_q <= FETCH;
        end
        FETCH: begin
          if (imem_rvalid && !redirect_valid) begin
            if_instr_q <= imem_rdata;
            if_pc_q    <= pc_q;
            pc_q       <= add_out;
            state_q    <= HOLD;
          end else if (imem_rvalid) begin
            pc_q <= tgt;
          end else if (redirect_valid) begin
            pend_q  <= tgt;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // Response to the abandoned request must still be consumed.
          if (imem_rvalid) begin
            pc_q    <= redirect_valid ? tgt : pend_q;
            state_q <= FETCH;
          end else if (redirect_valid) begin
            pend_q <= tgt;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc_q    <= tgt;
            state_q <= FETCH;
          end else if (if_ready) begin
            cnt_q   <= cnt_q + 32'd1;
            state_q <= FETCH;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign add_a     = pc_q;
  assign add_b     = PC_STEP;
  assign imem_addr = pc_q;
  assign imem_req  = (state_q == FETCH);
  assign if_valid  = (state_q == HOLD);
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed bench for fetch_pc_stage; a second instance with a wrapping
// RESET_PC runs in lockstep on the same stimulus.
module tb_fetch_pc_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_ready;

  logic [63:0] a0, b0, s0, addr0, pc0;
  logic        req0, v0;
  logic [31:0] ins0, cnt0;
  logic [63:0] a1, b1, s1, addr1, pc1;
  logic        req1, v1;
  logic [31:0] ins1, cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign s0 = a0 + b0;
  assign s1 = a1 + b1;

  fetch_pc_stage u0 (
    .clk(clk), .rst_n(rst_n),
    .add_a(a0), .add_b(b0), .add_out(s0),
    .imem_req(req0), .imem_addr(addr0),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(v0), .if_pc(pc0), .if_instr(ins0),
    .if_ready(if_ready), .fetch_cnt(cnt0)
  );

  fetch_pc_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u1 (
    .clk(clk), .rst_n(rst_n),
    .add_a(a1), .add_b(b1), .add_out(s1),
    .imem_req(req1), .imem_addr(addr1),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(v1), .if_pc(pc1), .if_instr(ins1),
    .if_ready(if_ready), .fetch_cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;
    if_ready = 1'b1;
    step();
    step();

    chk("rst_req", 64'(req0), 64'd0);
    chk("rst_valid", 64'(v0), 64'd0);
    chk("rst_pc", pc0, 64'h0);
    chk("rst_instr", 64'(ins0), 64'h0);
    chk("rst_cnt", 64'(cnt0), 64'h0);
    chk("rst_add_a", a0, 64'h0);
    chk("rst_add_b", b0, 64'd4);
    chk("rst_add_a_wrap", a1, 64'hFFFF_FFFF_FFFF_FFFC);

    rst_n = 1'b1;
    chk("boot_req", 64'(req0), 64'd0);
    step();
    chk("first_req", 64'(req0), 64'd1);

    for (int i = 0; i < 3; i++) begin
      chk("seq_addr", addr0, 64'(4 * i));
      imem_rvalid = 1'b1;
      imem_rdata = 32'h13 + 32'(i);
      step();
      imem_rvalid = 1'b0;
      chk("seq_valid", 64'(v0), 64'd1);
      chk("seq_pc", pc0, 64'(4 * i));
      chk("seq_instr", 64'(ins0), 64'(32'h13 + 32'(i)));
      step();
    end
    chk("seq_cnt", 64'(cnt0), 64'd3);
    chk("seq_next_addr", addr0, 64'hC);

    if_ready = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0050_0093;
    step();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 64'(v0), 64'd1);
      chk("hold_pc", pc0, 64'hC);
      chk("hold_instr", 64'(ins0), 64'h0050_0093);
      chk("hold_no_req", 64'(req0), 64'd0);
      step();
    end
    if_ready = 1'b1;
    step();
    chk("hold_cnt", 64'(cnt0), 64'd4);
    chk("hold_next_addr", addr0, 64'h10);
    chk("hold_next_req", 64'(req0), 64'd1);

    redirect_valid = 1'b1;
    redirect_pc = 64'h1000;
    step();
    redirect_valid = 1'b0;
    chk("drain_addr1", addr0, 64'h10);
    step();
    chk("drain_addr2", addr0, 64'h10);
    chk("drain_valid", 64'(v0), 64'd0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    chk("drain_discard", 64'(v0), 64'd0);
    chk("drain_target", addr0, 64'h1000);
    chk("drain_req", 64'(req0), 64'd1);

    imem_rvalid = 1'b1;
    imem_rdata = 32'h1111_1111;
    step();
    imem_rvalid = 1'b0;
    chk("sq_held", 64'(v0), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc = 64'h2002;
    step();
    redirect_valid = 1'b0;
    chk("sq_cnt", 64'(cnt0), 64'd4);
    chk("sq_valid", 64'(v0), 64'd0);
    chk("sq_addr", addr0, 64'h2000);

    redirect_valid = 1'b1;
    redirect_pc = 64'h3000;
    step();
    redirect_pc = 64'h4000;
    step();
    redirect_valid = 1'b0;
    chk("dd_addr_stable", addr0, 64'h2000);
    imem_rvalid = 1'b1;
    step();
    imem_rvalid = 1'b0;
    chk("dd_addr", addr0, 64'h4000);
    chk("dd_valid", 64'(v0), 64'd0);

    imem_rvalid = 1'b1;
    imem_rdata = 32'h2222_2222;
    step();
    imem_rvalid = 1'b0;
    chk("dd_if_pc", pc0, 64'h4000);
    step();
    chk("dd_cnt", 64'(cnt0), 64'd5);
    chk("dd_next", addr0, 64'h4004);

    imem_rvalid = 1'b1;
    step();
    imem_rvalid = 1'b0;
    chk("ar_pre_valid", 64'(v0), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(v0), 64'd0);
    chk("ar_pc", addr0, 64'h0);
    chk("ar_cnt", 64'(cnt0), 64'd0);
    chk("ar_pc_wrap", addr1, 64'hFFFF_FFFF_FFFF_FFFC);

    step();
    rst_n = 1'b1;
    step();
    chk("wrap_addr0", addr1, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_rvalid = 1'b1;
    imem_rdata = 32'h3333_3333;
    step();
    imem_rvalid = 1'b0;
    chk("wrap_if_pc", pc1, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    chk("wrap_addr", addr1, 64'h0);
    chk("wrap_cnt", 64'(cnt1), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
